alu_ctrl_muldiv: RTL and testbench
==================================

Name: alu_ctrl_muldiv

Overview:
Next-generation EX-stage ALU control for the multistage MIPS pipeline.
- Combinational decode: ALUOp/funct to a 4-bit ALU operation code, extended to the full R-type integer set.
- Sequential part: an iterative multiply/divide unit with HI/LO registers and a pipeline stall handshake.
- Sits between the ID/EX register and the ALU; the hazard unit consumes `stall`.

Parameters:
- WIDTH, 32, operand/HI/LO width (>=4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  EX-stage instruction valid
- ALUOp  in  4  main-control ALU class
- funct  in  6  instruction funct field
- rs_val  in  WIDTH  operand A / dividend / MTHI-MTLO source
- rt_val  in  WIDTH  operand B / divisor
- alu_ctrl_out  out  4  ALU operation code
- hilo_sel  out  2  EX result mux: 00 ALU, 01 HI, 10 LO
- stall  out  1  freeze IF/ID/EX this cycle
- md_busy  out  1  multiply/divide in progress
- md_done  out  1  one-cycle pulse when HI/LO updated by MULT/DIV
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:

Decode (combinational, independent of valid_in):
- ALUOp 0000 (LW/SW/ADDI/ADDIU) -> 0010
- 0001 BEQ -> 0110
- 0011 LUI -> 0101
- 0100 ORI -> 0001
- 0101 ANDI -> 0000
- 0110 SLTI -> 0111
- 0111 XORI -> 0011
- 0010 R-type, by funct:
  - ADD/ADDU 10000x -> 0010
  - SUB/SUBU 10001x -> 0110
  - AND -> 0000; OR -> 0001; XOR -> 0011
  - NOR 100111 -> 1100
  - SLT -> 0111; SLTU 101011 -> 1001
  - SLL 000000 -> 1000; SRL 000010 -> 1010; SRA 000011 -> 1011
  - Any other funct -> 1111
- Unlisted ALUOp -> 1111. 1111 = no-op/zero result; there is no latch-inferring default.
- hilo_sel: 01 for MFHI 010000, 10 for MFLO 010010, else 00.

MD class (R-type funct): MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI, MTHI 010001, MFLO, MTLO 010011.
- stall = valid_in & R-type & MD-class & (state != IDLE); combinational.
- An instruction issued while state == IDLE never stalls.

State machine: IDLE, ITER, FIX.
- IDLE, on MULT/MULTU/DIV/DIVU with valid_in:
  - Latch |rs|, |rt| (signed ops only; unsigned operands taken as-is).
  - Record result signs, clear accumulator, cnt = WIDTH.
  - Go to ITER.
  - Exception: DIV/DIVU with rt_val == 0 goes directly to FIX.
- ITER:
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring shift-subtract step per cycle.
  - cnt decrements; at cnt == 1 go to FIX. Exactly WIDTH cycles in ITER.
- FIX: apply sign correction, write hi/lo, pulse md_done, go to IDLE.
- Latency: start edge + WIDTH ITER + 1 FIX. md_busy high for WIDTH+1 cycles; hi/lo valid the cycle md_done is high.

Result rules:
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Most-negative / -1: lo = most-negative, hi = 0 (wrap).
- Divide by zero: lo = all ones, hi = rs_val; busy for 1 cycle only.
- MULT results: hi = upper WIDTH bits, lo = lower WIDTH bits of the 2*WIDTH product.

MTHI/MTLO:
- Write at the clock edge when valid_in and IDLE.
- When busy they stall and are not applied until IDLE.
- A new MULT/DIV while busy stalls; it is held by the pipeline and accepted once IDLE.

Reset (any time, including mid-operation):
- state IDLE; hi = lo = 0; md_busy = 0; md_done = 0; cnt = 0.
- In-flight operation discarded.
- Combinational outputs follow inputs.

Test Plan:
- Decode sweep: ALUOp 0010 with funct 100111 -> 1100; 000011 -> 1011; 111111 -> 1111. ALUOp 0101 -> 0000. ALUOp 1000 -> 1111.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> md_done exactly 33 cycles after the start edge; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV rs=-7, rt=2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU rt=0, rs=0x1234 -> busy 1 cycle; lo = 0xFFFFFFFF, hi = 0x1234.
- MFLO issued 5 cycles after a MULT start -> stall high until state returns to IDLE, then hilo_sel = 10 with the updated lo. MTHI 0xA5A5A5A5 while idle -> hi updates next edge with no stall.
- rst_n low at ITER cycle 10 -> immediately hi = lo = 0, md_busy = 0. After release, a new MULT 2*3 -> lo = 6.

Source files
------------

// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv: EX-stage ALU decode plus iterative multiply/divide unit with HI/LO and stall
module alu_ctrl_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [3:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       alu_ctrl_out,
    output logic [1:0]       hilo_sel,
    output logic             stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   p_hi, p_lo, b, abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic               is_r, md_class, is_md_op, is_div, is_signed, start, div_zero;
    logic               div_op, dz_r, neg_q, neg_r;
    assign is_r      = ALUOp == 4'b0010;
    assign is_md_op  = is_r & (funct[5:2] == 4'b0110);
    assign md_class  = is_md_op | (is_r & (funct[5:2] == 4'b0100));
    assign is_div    = funct[1];
    assign is_signed = ~funct[0];
    assign start     = valid_in & is_md_op & (state == IDLE);
    assign div_zero  = is_div & (rt_val == '0);
    assign abs_a     = (is_signed & rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign abs_b     = (is_signed & rt_val[WIDTH-1]) ? -rt_val : rt_val;
    assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, b} : '0);
    assign div_trial = {p_hi, p_lo[WIDTH-1]} - {1'b0, b};
    assign prod      = {p_hi, p_lo};
    assign stall     = valid_in & md_class & (state != IDLE);
    assign md_busy   = state != IDLE;
    assign hilo_sel  = (is_r & funct == 6'b010000) ? 2'b01 :
                       (is_r & funct == 6'b010010) ? 2'b10 : 2'b00;
    always_comb begin
        alu_ctrl_out = 4'b1111;
        case (ALUOp)
            4'b0000: alu_ctrl_out = 4'b0010;
            4'b0001: alu_ctrl_out = 4'b0110;
            4'b0011: alu_ctrl_out = 4'b0101;
            4'b0100: alu_ctrl_out = 4'b0001;
            4'b0101: alu_ctrl_out = 4'b0000;
            4'b0110: alu_ctrl_out = 4'b0111;
            4'b0111: alu_ctrl_out = 4'b0011;
            4'b0010:
                casez (funct)
                    6'b10000?: alu_ctrl_out = 4'b0010;
                    6'b10001?: alu_ctrl_out = 4'b0110;
                    6'b100100: alu_ctrl_out = 4'b0000;
                    6'b100101: alu_ctrl_out = 4'b0001;
                    6'b100110: alu_ctrl_out = 4'b0011;
                    6'b100111: alu_ctrl_out = 4'b1100;
                    6'b101010: alu_ctrl_out = 4'b0111;
                    6'b101011: alu_ctrl_out = 4'b1001;
                    6'b000000: alu_ctrl_out = 4'b1000;
                    6'b000010: alu_ctrl_out = 4'b1010;
                    6'b000011: alu_ctrl_out = 4'b1011;
                    default:   alu_ctrl_out = 4'b1111;
                endcase
            default: alu_ctrl_out = 4'b1111;
        endcase
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (div_zero ? FIX : ITER) : IDLE;
            ITER:    state_nx = (cnt == CNT_W'(1)) ? FIX : ITER;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            b       <= '0;
            div_op  <= 1'b0;
            dz_r    <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            md_done <= 1'b0;
        end else begin
            state   <= state_nx;
            md_done <= 1'b0;
            case (state)
                IDLE:
                    if (start) begin
                        div_op <= is_div;
                        dz_r   <= div_zero;
                        neg_q  <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_r  <= is_signed & rs_val[WIDTH-1];
                        cnt    <= CNT_W'(WIDTH);
                        b      <= abs_b;
                        p_hi   <= div_zero ? rs_val : '0;
                        p_lo   <= abs_a;
                    end else if (valid_in & is_r & funct == 6'b010001) begin
                        hi <= rs_val;
                    end else if (valid_in & is_r & funct == 6'b010011) begin
                        lo <= rs_val;
                    end
                ITER: begin
                    cnt <= cnt - 1'b1;
                    if (div_op) begin
                        p_hi <= div_trial[WIDTH] ? {p_hi[WIDTH-2:0], p_lo[WIDTH-1]} : div_trial[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], ~div_trial[WIDTH]};
                    end else begin
                        p_hi <= mul_sum[WIDTH:1];
                        p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    md_done <= 1'b1;
                    if (dz_r) begin
                        hi <= p_hi;
                        lo <= '1;
                    end else if (div_op) begin
                        hi <= neg_r ? -p_hi : p_hi;
                        lo <= neg_q ? -p_lo : p_lo;
                    end else begin
                        {hi, lo} <= neg_q ? -prod : prod;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb_alu_ctrl_muldiv: directed and randomized checks of decode and multiply/divide against an arithmetic model
module tb_alu_ctrl_muldiv;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0;
    logic [3:0]   ALUOp = '0;
    logic [5:0]   funct = '0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic [3:0]   alu_ctrl_out;
    logic [1:0]   hilo_sel;
    logic         stall, md_busy, md_done;
    logic [W-1:0] hi, lo;
    int checks = 0;
    int failures = 0;

    alu_ctrl_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ALUOp(ALUOp), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .alu_ctrl_out(alu_ctrl_out), .hilo_sel(hilo_sel),
        .stall(stall), .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint     sa = longint'($signed(a));
        longint     sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] q, r;
        if (f[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
        case (f[1:0])
            2'd0: return sa * sb;
            2'd1: return ua * ub;
            2'd2: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
            default: begin q = ua / ub; r = ua % ub; return {r[31:0], q[31:0]}; end
        endcase
    endfunction

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1'b1; ALUOp = 4'b0010; funct = f; rs_val = a; rt_val = b;
    endtask

    task automatic idle_in();
        valid_in = 1'b0; ALUOp = 4'b0000; funct = 6'b0;
    endtask

    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int lat = (f[1] && b == 32'd0) ? 1 : W + 1;
        int n = 0;
        int busy;
        @(negedge clk);
        issue(f, a, b);
        #1 check({tag, " stall_idle"}, stall, 0);
        @(negedge clk);
        idle_in();
        busy = md_busy;
        while (!md_done && n < 200) begin
            @(negedge clk);
            n++;
            busy += md_busy;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " busy_cycles"}, busy, lat);
        check({tag, " hilo"}, {hi, lo}, exp);
        @(negedge clk);
        check({tag, " done_pulse"}, md_done, 0);
    endtask

    logic [15:0] dec [27] = '{
        {4'h0, 6'h00, 4'h2, 2'd0}, {4'h1, 6'h00, 4'h6, 2'd0}, {4'h3, 6'h00, 4'h5, 2'd0},
        {4'h4, 6'h00, 4'h1, 2'd0}, {4'h5, 6'h00, 4'h0, 2'd0}, {4'h6, 6'h00, 4'h7, 2'd0},
        {4'h7, 6'h00, 4'h3, 2'd0}, {4'h8, 6'h00, 4'hF, 2'd0}, {4'hF, 6'h2A, 4'hF, 2'd0},
        {4'h2, 6'b100000, 4'h2, 2'd0}, {4'h2, 6'b100001, 4'h2, 2'd0}, {4'h2, 6'b100010, 4'h6, 2'd0},
        {4'h2, 6'b100011, 4'h6, 2'd0}, {4'h2, 6'b100100, 4'h0, 2'd0}, {4'h2, 6'b100101, 4'h1, 2'd0},
        {4'h2, 6'b100110, 4'h3, 2'd0}, {4'h2, 6'b100111, 4'hC, 2'd0}, {4'h2, 6'b101010, 4'h7, 2'd0},
        {4'h2, 6'b101011, 4'h9, 2'd0}, {4'h2, 6'b000000, 4'h8, 2'd0}, {4'h2, 6'b000010, 4'hA, 2'd0},
        {4'h2, 6'b000011, 4'hB, 2'd0}, {4'h2, 6'b111111, 4'hF, 2'd0}, {4'h2, 6'b011000, 4'hF, 2'd0},
        {4'h2, 6'b010000, 4'hF, 2'd1}, {4'h2, 6'b010010, 4'hF, 2'd2}, {4'h0, 6'b010000, 4'h2, 2'd0}
    };

    initial begin
        logic [63:0] m;
        logic [5:0]  f;
        logic [31:0] a, b;
        int          n;
        repeat (2) @(negedge clk);
        #1;
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", md_busy, 0);
        check("reset done", md_done, 0);
        check("reset stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            ALUOp = dec[i][15:12];
            funct = dec[i][11:6];
            #1;
            check($sformatf("decode%0d alu", i), alu_ctrl_out, dec[i][5:2]);
            check($sformatf("decode%0d hilo_sel", i), hilo_sel, dec[i][1:0]);
        end
        idle_in();

        run_md("mult_m3x7", 6'b011000, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run_md("multu_max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_md("div_m7_2", 6'b011010, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_md("div_minneg", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_md("divu_zero", 6'b011011, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        run_md("div_zero_neg", 6'b011010, 32'h8765_4321, 32'd0, 64'h8765_4321_FFFF_FFFF);

        @(negedge clk);
        issue(6'b010001, 32'hA5A5_A5A5, 32'd0);
        #1 check("mthi stall", stall, 0);
        @(negedge clk);
        idle_in();
        check("mthi hi", hi, 32'hA5A5_A5A5);
        @(negedge clk);
        issue(6'b010011, 32'h5A5A_0F0F, 32'd0);
        @(negedge clk);
        idle_in();
        check("mtlo lo", lo, 32'h5A5A_0F0F);

        a = $urandom;
        b = $urandom;
        m = model(6'b011000, a, b);
        @(negedge clk);
        issue(6'b011000, a, b);
        @(negedge clk);
        idle_in();
        repeat (5) @(negedge clk);
        issue(6'b010010, 32'd0, 32'd0);
        #1 check("mflo stall_busy", stall, 1);
        n = 0;
        while (stall && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mflo stall_cycles", n, W - 4);
        check("mflo hilo_sel", hilo_sel, 2'b10);
        check("mflo lo", lo, m[31:0]);
        check("mflo done", md_done, 1);
        @(negedge clk);
        idle_in();

        @(negedge clk);
        issue(6'b011001, 32'h0001_0003, 32'h0002_0005);
        @(negedge clk);
        idle_in();
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset hi", hi, 0);
        check("midreset lo", lo, 0);
        check("midreset busy", md_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_md("post_reset_mult", 6'b011000, 32'd2, 32'd3, 64'd6);

        for (int i = 0; i < 14; i++) begin
            f = 6'b011000 | 6'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 300));
                2: b = -32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            run_md($sformatf("rnd%0d", i), f, a, b, model(f, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
